// File: rtl/alu_serial_exec.sv
// Execute-stage ALU: single-cycle logic/arith/compare ops plus a bit-serial shifter,
// with valid/ready handshakes on both sides and registered result, Zero and illegal.
module alu_serial_exec #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            Operation,
    input  logic [DATA_WIDTH-1:0] SrcA,
    input  logic [DATA_WIDTH-1:0] SrcB,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] ALUResult,
    output logic                  Zero,
    output logic                  illegal
);
    localparam int SW = $clog2(DATA_WIDTH);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] res;
    logic                  zero_q;
    logic                  ill_q;
    logic [SW-1:0]         cnt;
    logic [1:0]            sop;

    logic [SW-1:0]         shamt;
    logic                  is_shift;
    logic                  ill_c;
    logic [DATA_WIDTH-1:0] res_c;
    logic [DATA_WIDTH-1:0] sh_next;

    // kind: 2'b10 SLL, 2'b11 SRL, otherwise SRA (Operation[1:0] of the shift codes)
    function automatic logic [DATA_WIDTH-1:0] shift1(input logic [1:0] kind,
                                                     input logic [DATA_WIDTH-1:0] v);
        case (kind)
            2'b10:   shift1 = {v[DATA_WIDTH-2:0], 1'b0};
            2'b11:   shift1 = {1'b0, v[DATA_WIDTH-1:1]};
            default: shift1 = {v[DATA_WIDTH-1], v[DATA_WIDTH-1:1]};
        endcase
    endfunction

    assign shamt   = SrcB[SW-1:0];
    assign sh_next = shift1(sop, res);

    always_comb begin
        res_c    = '0;
        ill_c    = 1'b0;
        is_shift = 1'b0;
        case (Operation)
            4'b0000: res_c = SrcA & SrcB;
            4'b0001: res_c = SrcA | SrcB;
            4'b0010: res_c = SrcA + SrcB;
            4'b0011: res_c = SrcA - SrcB;
            4'b0100: res_c = SrcA ^ SrcB;
            4'b0101, 4'b0110, 4'b0111: begin
                is_shift = 1'b1;
                res_c    = (shamt == '0) ? SrcA : shift1(Operation[1:0], SrcA);
            end
            4'b1000: res_c[0] = (SrcA == SrcB);
            4'b1001: res_c[0] = ($signed(SrcA) < $signed(SrcB));
            4'b1010: res_c[0] = (SrcA != SrcB);
            4'b1011: res_c[0] = ($signed(SrcA) < $signed(SrcB));
            4'b1100: res_c[0] = ($signed(SrcA) >= $signed(SrcB));
            default: ill_c = 1'b1;
        endcase
    end

    // The first shift happens in the acceptance cycle, so a shift of N bits
    // reaches DONE N cycles after acceptance; SHIFT performs the remaining N-1.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            res    <= '0;
            zero_q <= 1'b1;
            ill_q  <= 1'b0;
            cnt    <= '0;
            sop    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sop   <= Operation[1:0];
                        ill_q <= ill_c;
                        res   <= res_c;
                        if (is_shift && (shamt > SW'(1))) begin
                            cnt   <= shamt - SW'(1);
                            state <= SHIFT;
                        end else begin
                            zero_q <= (res_c == '0);
                            state  <= DONE;
                        end
                    end
                end
                SHIFT: begin
                    res <= sh_next;
                    cnt <= cnt - SW'(1);
                    if (cnt == SW'(1)) begin
                        zero_q <= (sh_next == '0);
                        state  <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign ALUResult = res;
    assign Zero      = zero_q;
    assign illegal   = ill_q;
endmodule

// File: tb/tb_alu_serial_exec.sv
// Directed self-checking bench for alu_serial_exec: latency, results, flags,
// backpressure and mid-shift reset, with hand-computed expected values.
module tb_alu_serial_exec;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  Operation;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] ALUResult;
    logic        Zero;
    logic        illegal;

    int total = 0;
    int bad   = 0;

    alu_serial_exec #(.DATA_WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Operation (Operation),
        .SrcA      (SrcA),
        .SrcB      (SrcB),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ALUResult (ALUResult),
        .Zero      (Zero),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Call in IDLE, #1 after a rising edge; returns in IDLE, #1 after an edge.
    task automatic run(input string tag, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int explat,
                       input logic expill);
        int   lat;
        logic rdy_seen;
        Operation = op; SrcA = a; SrcB = b; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; Operation = 4'hF; SrcA = '1; SrcB = '1;
        lat = 1;
        rdy_seen = 1'b0;
        while (!out_valid && lat < 100) begin
            rdy_seen |= in_ready;
            @(posedge clk); #1;
            lat++;
        end
        rdy_seen |= in_ready;
        chk({tag, " valid"},   32'(out_valid), 32'd1);
        chk({tag, " latency"}, 32'(lat), 32'(explat));
        chk({tag, " result"},  ALUResult, exp);
        chk({tag, " zero"},    32'(Zero), 32'(exp == 32'd0));
        chk({tag, " illegal"}, 32'(illegal), 32'(expill));
        chk({tag, " in_ready low"}, 32'(rdy_seen), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        int seen;
        reset = 1'b1; in_valid = 1'b0; Operation = '0; SrcA = '0; SrcB = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst in_ready",  32'(in_ready),  32'd1);
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst result",    ALUResult,      32'd0);
        chk("rst zero",      32'(Zero),      32'd1);
        chk("rst illegal",   32'(illegal),   32'd0);
        reset = 1'b0;

        run("add",      4'b0010, 32'h7FFF_FFFF, 32'd1,          32'h8000_0000, 1,  1'b0);
        run("sub",      4'b0011, 32'd5,         32'd5,          32'd0,         1,  1'b0);
        run("and",      4'b0000, 32'h0000_F0F0, 32'h0000_0FF0,  32'h0000_00F0, 1,  1'b0);
        run("or",       4'b0001, 32'h0000_F0F0, 32'h0000_0FF0,  32'h0000_FFF0, 1,  1'b0);
        run("sra31",    4'b0101, 32'h8000_0000, 32'd31,         32'hFFFF_FFFF, 31, 1'b0);
        run("srl31",    4'b0111, 32'h8000_0000, 32'd31,         32'h0000_0001, 31, 1'b0);
        run("sll4",     4'b0110, 32'd1,         32'h24,         32'h0000_0010, 4,  1'b0);
        run("sll0",     4'b0110, 32'hA5A5_A5A5, 32'h20,         32'hA5A5_A5A5, 1,  1'b0);
        run("srl1",     4'b0111, 32'h8000_0000, 32'd1,          32'h4000_0000, 1,  1'b0);
        run("sra2pos",  4'b0101, 32'h4000_0000, 32'd2,          32'h1000_0000, 2,  1'b0);
        run("blt",      4'b1011, 32'hFFFF_FFFF, 32'd1,          32'd1,         1,  1'b0);
        run("bge",      4'b1100, 32'hFFFF_FFFF, 32'd1,          32'd0,         1,  1'b0);
        run("slt",      4'b1001, 32'd1,         32'hFFFF_FFFF,  32'd0,         1,  1'b0);
        run("beq",      4'b1000, 32'h1234,      32'h1234,       32'd1,         1,  1'b0);
        run("bne",      4'b1010, 32'h1234,      32'h1234,       32'd0,         1,  1'b0);
        run("reserved", 4'b1110, 32'h1234,      32'h5678,       32'd0,         1,  1'b1);

        // Backpressure: result held, a pending op waits until the cycle after out_ready.
        out_ready = 1'b0;
        Operation = 4'b0100; SrcA = 32'h0000_F0F0; SrcB = 32'h0000_0FF0; in_valid = 1'b1;
        @(posedge clk); #1;
        Operation = 4'b0010; SrcA = 32'd2; SrcB = 32'd3;
        for (int i = 0; i < 5; i++) begin
            chk("bp out_valid", 32'(out_valid), 32'd1);
            chk("bp result",    ALUResult,      32'h0000_FF00);
            chk("bp in_ready",  32'(in_ready),  32'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp release in_ready",  32'(in_ready),  32'd1);
        chk("bp release out_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp next valid",  32'(out_valid), 32'd1);
        chk("bp next result", ALUResult,      32'd5);
        @(posedge clk); #1;

        // Reset during a 20-bit shift, ten cycles after acceptance.
        Operation = 4'b0110; SrcA = 32'd1; SrcB = 32'd20; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        seen = 0;
        for (int i = 0; i < 9; i++) begin
            if (out_valid) seen++;
            @(posedge clk); #1;
        end
        chk("mid shift in_ready", 32'(in_ready), 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("shift rst in_ready",  32'(in_ready),  32'd1);
        chk("shift rst out_valid", 32'(out_valid), 32'd0);
        chk("shift rst result",    ALUResult,      32'd0);
        chk("shift rst zero",      32'(Zero),      32'd1);
        for (int i = 0; i < 30; i++) begin
            if (out_valid) seen++;
            @(posedge clk); #1;
        end
        chk("shift rst no output", 32'(seen), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
